issue_queue: RTL
================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter SIZE, default 8, meaning entry count (power of two, 2..16).
REQ-002 SHALL have parameter NUM_WBS, default 3, meaning writeback wakeup ports.
REQ-003 SHALL have parameter NUM_ZC_FWDS, default 2, meaning zero-cycle forward wakeup ports.
REQ-004 SHALL have parameter PAYLOAD_W, default 64, meaning opaque uop payload width.
REQ-005 SHALL have the following ports, with one clock and synchronous active-high reset:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- IN_valid  in  1  enqueue request
- IN_tagA / IN_tagB  in  6 each  source register tags
- IN_availA / IN_availB  in  1 each  operand already available
- IN_sqN  in  6  sequence number
- IN_payload  in  PAYLOAD_W  opaque fields
- OUT_full  out  1  no free entry
- IN_wbHasResult  in  NUM_WBS  writeback valid
- IN_wbTag  in  NUM_WBS*6  writeback tags
- IN_zcFwdValid  in  NUM_ZC_FWDS  forward valid
- IN_zcFwdTag  in  NUM_ZC_FWDS*6  forward tags
- IN_invalidate  in  1  flush request
- IN_invalidateSqN  in  6  flush boundary
- IN_stall  in  1  operand-fetch stage cannot accept
- OUT_valid  out  1  issued uop valid
- OUT_tagA / OUT_tagB  out  6 each  issued tags
- OUT_sqN  out  6  issued sequence number
- OUT_payload  out  PAYLOAD_W  issued payload
- OUT_count  out  5  occupied entries

Function
REQ-006 SHALL accept an enqueue when IN_valid && !OUT_full, writing the first free entry (lowest index).
REQ-007 SHALL drive OUT_full = (OUT_count == SIZE), derived from registered state only.
REQ-008 SHALL ignore IN_valid while OUT_full; an entry freed in the same cycle SHALL NOT be reused that cycle.
REQ-009 SHALL set an entry's availX when any IN_wbHasResult[j] has IN_wbTag[j] == tagX, including for an entry being enqueued that same cycle.
REQ-010 SHALL treat an entry as ready when availA && availB.
REQ-011 SHALL, when !IN_stall, select the oldest ready entry, i.e. minimal signed 6-bit (sqN - other.sqN), register it onto the OUT_* ports, and free the entry.
REQ-012 SHALL issue no entry when IN_stall; OUT_* SHALL hold their values.
REQ-013 SHALL clear OUT_valid when !IN_stall and no entry is ready.
REQ-014 SHALL set issue latency to 1 cycle minimum: a uop enqueued ready at cycle N appears on OUT_valid at N+1; a wakeup at cycle N enables issue at N+1.
REQ-015 SHALL, on IN_invalidate, free every entry with signed 6-bit (sqN - IN_invalidateSqN) > 0 in the same cycle, exclude those entries from selection, and drop a younger incoming uop.
REQ-016 SHALL clear OUT_valid on IN_invalidate if the registered or newly selected uop is younger than IN_invalidateSqN, regardless of IN_stall.
REQ-017 SHALL update OUT_count = count + enq - issue - flushed each cycle, never exceeding SIZE.

Reset
REQ-018 SHALL, with rst high at a clock edge, clear all entry valid bits, OUT_valid=0 and OUT_count=0; OUT_full=0 follows.
REQ-019 SHALL not reset OUT_tagA, OUT_tagB, OUT_sqN or OUT_payload.
REQ-020 SHALL give rst priority over enqueue, issue and invalidate in the same cycle.

Configuration
REQ-021 SHALL, with ISSUE_QUEUE_ZC_WAKEUP_EN defined, additionally set availX on IN_zcFwdValid[j] && IN_zcFwdTag[j] == tagX, including for entries being enqueued.
REQ-022 SHALL, without ISSUE_QUEUE_ZC_WAKEUP_EN, ignore the IN_zcFwd* ports entirely.

Verification
REQ-023 Reset then enqueue sqN=5 with availA=availB=1 -> OUT_valid=1, OUT_sqN=5 next cycle, OUT_count back to 0.
REQ-024 Enqueue sqN=3 (tagA=12 unavailable), then sqN=4 ready -> sqN=4 issues first; IN_wbTag=12 -> sqN=3 issues the cycle after the wakeup.
REQ-025 Fill 8 ready entries with IN_stall=1 -> OUT_full=1 and a 9th IN_valid is dropped; release stall -> issue order follows sqN, with wrap case sqN 62,63,0,1 issuing in that order.
REQ-026 Entries sqN 10..14, IN_invalidate with IN_invalidateSqN=11 -> only 10 and 11 remain, OUT_count=2, and a simultaneous enqueue of sqN=15 is dropped.
REQ-027 With ISSUE_QUEUE_ZC_WAKEUP_EN defined, IN_zcFwdTag=7 wakes a waiting entry with tagB=7 -> it issues next cycle; without the macro -> it stays waiting.

Source files
------------

// File: rtl/issue_queue.sv
// Issue queue: buffers uops until both operands are awake, then issues the oldest ready one per cycle.
// Define ISSUE_QUEUE_ZC_WAKEUP_EN to also wake operands from the zero-cycle forward ports.
module issue_queue #(
  parameter int SIZE        = 8,
  parameter int NUM_WBS     = 3,
  parameter int NUM_ZC_FWDS = 2,
  parameter int PAYLOAD_W   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     IN_valid,
  input  logic [5:0]               IN_tagA,
  input  logic [5:0]               IN_tagB,
  input  logic                     IN_availA,
  input  logic                     IN_availB,
  input  logic [5:0]               IN_sqN,
  input  logic [PAYLOAD_W-1:0]     IN_payload,
  output logic                     OUT_full,
  input  logic [NUM_WBS-1:0]       IN_wbHasResult,
  input  logic [NUM_WBS*6-1:0]     IN_wbTag,
  input  logic [NUM_ZC_FWDS-1:0]   IN_zcFwdValid,
  input  logic [NUM_ZC_FWDS*6-1:0] IN_zcFwdTag,
  input  logic                     IN_invalidate,
  input  logic [5:0]               IN_invalidateSqN,
  input  logic                     IN_stall,
  output logic                     OUT_valid,
  output logic [5:0]               OUT_tagA,
  output logic [5:0]               OUT_tagB,
  output logic [5:0]               OUT_sqN,
  output logic [PAYLOAD_W-1:0]     OUT_payload,
  output logic [4:0]               OUT_count
);

  localparam int IDX_W = $clog2(SIZE);

  // Handshake: an enqueue is taken when IN_valid && !OUT_full; the issue slot
  // advances only while !IN_stall and otherwise holds OUT_* unchanged.
  logic [SIZE-1:0]      r_valid;
  logic [SIZE-1:0]      r_avail_a;
  logic [SIZE-1:0]      r_avail_b;
  logic [5:0]           r_tag_a   [SIZE];
  logic [5:0]           r_tag_b   [SIZE];
  logic [5:0]           r_sqn     [SIZE];
  logic [PAYLOAD_W-1:0] r_payload [SIZE];
  logic [4:0]           r_count;

  logic                 r_out_valid;
  logic [5:0]           r_out_tag_a;
  logic [5:0]           r_out_tag_b;
  logic [5:0]           r_out_sqn;
  logic [PAYLOAD_W-1:0] r_out_payload;

  logic                 w_in_flush;
  logic                 w_enq;
  logic                 w_in_avail_a;
  logic                 w_in_avail_b;
  logic [IDX_W-1:0]     w_free_idx;
  logic [SIZE-1:0]      w_wake_a;
  logic [SIZE-1:0]      w_wake_b;
  logic [SIZE-1:0]      w_flush;
  logic [SIZE-1:0]      w_ready;
  logic                 w_sel_valid;
  logic [IDX_W-1:0]     w_sel_idx;
  logic [SIZE-1:0]      w_valid_next;
  logic [4:0]           w_count_next;

  // Sequence numbers wrap at 64, so age is the sign of the 6-bit difference.
  function automatic logic younger(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] d;
    d = a - b;
    return (d != 6'd0) && !d[5];
  endfunction

  function automatic logic older(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] d;
    d = a - b;
    return d[5];
  endfunction

  function automatic logic wake_hit(input logic [5:0] tag);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < NUM_WBS; j++)
      if (IN_wbHasResult[j] && IN_wbTag[j*6 +: 6] == tag) hit = 1'b1;
`ifdef ISSUE_QUEUE_ZC_WAKEUP_EN
    for (int j = 0; j < NUM_ZC_FWDS; j++)
      if (IN_zcFwdValid[j] && IN_zcFwdTag[j*6 +: 6] == tag) hit = 1'b1;
`endif
    return hit;
  endfunction

`ifndef ISSUE_QUEUE_ZC_WAKEUP_EN
  logic w_unused_zc;
  assign w_unused_zc = ^{IN_zcFwdValid, IN_zcFwdTag};
`endif

  assign OUT_full    = (r_count == 5'(SIZE));
  assign OUT_count   = r_count;
  assign OUT_valid   = r_out_valid;
  assign OUT_tagA    = r_out_tag_a;
  assign OUT_tagB    = r_out_tag_b;
  assign OUT_sqN     = r_out_sqn;
  assign OUT_payload = r_out_payload;

  always_comb begin
    w_in_flush   = IN_invalidate && younger(IN_sqN, IN_invalidateSqN);
    w_enq        = IN_valid && !OUT_full && !w_in_flush;
    w_in_avail_a = IN_availA || wake_hit(IN_tagA);
    w_in_avail_b = IN_availB || wake_hit(IN_tagB);

    w_free_idx = '0;
    for (int i = SIZE - 1; i >= 0; i--)
      if (!r_valid[i]) w_free_idx = IDX_W'(i);

    w_wake_a = '0;
    w_wake_b = '0;
    w_flush  = '0;
    w_ready  = '0;
    for (int i = 0; i < SIZE; i++) begin
      w_wake_a[i] = wake_hit(r_tag_a[i]);
      w_wake_b[i] = wake_hit(r_tag_b[i]);
      w_flush[i]  = r_valid[i] && IN_invalidate && younger(r_sqn[i], IN_invalidateSqN);
      w_ready[i]  = r_valid[i] && !w_flush[i] && r_avail_a[i] && r_avail_b[i];
    end

    // Oldest-first pick; ties (duplicate sqN) fall to the lowest index.
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    if (!IN_stall) begin
      for (int i = 0; i < SIZE; i++) begin
        if (w_ready[i] && (!w_sel_valid || older(r_sqn[i], r_sqn[w_sel_idx]))) begin
          w_sel_valid = 1'b1;
          w_sel_idx   = IDX_W'(i);
        end
      end
    end

    w_valid_next = r_valid & ~w_flush;
    if (w_sel_valid) w_valid_next[w_sel_idx] = 1'b0;
    if (w_enq) w_valid_next[w_free_idx] = 1'b1;

    w_count_next = '0;
    for (int i = 0; i < SIZE; i++)
      w_count_next = w_count_next + {4'b0, w_valid_next[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_valid <= w_valid_next;
      r_count <= w_count_next;
      if (!IN_stall)
        r_out_valid <= w_sel_valid;
      else if (IN_invalidate && younger(r_out_sqn, IN_invalidateSqN))
        r_out_valid <= 1'b0;
    end
  end

  // Payload-side storage carries no reset; only the valid bits above matter.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      if (w_enq && w_free_idx == IDX_W'(i)) begin
        r_tag_a[i]   <= IN_tagA;
        r_tag_b[i]   <= IN_tagB;
        r_sqn[i]     <= IN_sqN;
        r_payload[i] <= IN_payload;
        r_avail_a[i] <= w_in_avail_a;
        r_avail_b[i] <= w_in_avail_b;
      end else begin
        if (w_wake_a[i]) r_avail_a[i] <= 1'b1;
        if (w_wake_b[i]) r_avail_b[i] <= 1'b1;
      end
    end
    if (!rst && w_sel_valid) begin
      r_out_tag_a   <= r_tag_a[w_sel_idx];
      r_out_tag_b   <= r_tag_b[w_sel_idx];
      r_out_sqn     <= r_sqn[w_sel_idx];
      r_out_payload <= r_payload[w_sel_idx];
    end
  end

endmodule
